// File: rtl/spectrum_pkg.sv
// Shared types for the spectrum-analysis sequencer: one-hot state encoding and detector mode codes.
package spectrum_pkg;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_KICK     = 8'b0000_0010,
    ST_FEED     = 8'b0000_0100,
    ST_WAIT_MAG = 8'b0000_1000,
    ST_DETECT   = 8'b0001_0000,
    ST_DONE     = 8'b0010_0000,
    ST_ERR      = 8'b0100_0000,
    ST_SPARE    = 8'b1000_0000
  } state_t;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_AM    = 3'b001;
  localparam logic [2:0] MODE_FM    = 3'b010;
  localparam logic [2:0] MODE_OTHER = 3'b100;

endpackage

// File: rtl/spectrum_ctrl_timer.sv
// Timeout counter: clr reloads zero, counts while en, expired once TIMEOUT_CYC cycles have elapsed.
module spectrum_ctrl_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TW'(1);
    end
  end

  // Holds at the terminal count so a stuck state keeps reporting expiry.
  assign expired = (cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/spectrum_ctrl.sv
// Spectrum-pass sequencer: ADC -> FFT feed, magnitude -> RAM write, then modulation_detect handshake.
// Build option SPECTRUM_CTRL_HALF_EN: only the lower FFT_N/2 bins are written to RAM.
module spectrum_ctrl
  import spectrum_pkg::*;
#(
  parameter int unsigned FFT_N       = 4096,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key,
  input  logic              auto_run,
  input  logic              adc_valid,
  output logic              fft_s_valid,
  output logic              fft_s_last,
  input  logic              fft_s_ready,
  input  logic              mag_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              det_en,
  output logic              det_key,
  input  logic              det_valid,
  input  logic [2:0]        det_mode,
  output logic [2:0]        mode_type,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_N - 1);

  state_t            state, nxt;
  logic              key_s1, key_s2, key_d;
  logic              start_c;
  logic [ADDR_W-1:0] beat_cnt;
  logic              bin_wr_ok_c;
  logic              tmr_clr, tmr_en, tmr_exp;

  assign start_c = key_d & ~key_s2;

`ifdef SPECTRUM_CTRL_HALF_EN
  assign bin_wr_ok_c = ~ram_waddr[ADDR_W-1];
`else
  assign bin_wr_ok_c = 1'b1;
`endif

  spectrum_ctrl_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next-state and per-state outputs; the timer is held clear outside the timed states.
  always_comb begin
    nxt         = state;
    fft_s_valid = 1'b0;
    fft_s_last  = 1'b0;
    ram_we      = 1'b0;
    det_en      = 1'b0;
    det_key     = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    tmr_en      = 1'b0;
    tmr_clr     = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start_c) nxt = ST_KICK;
      end
      ST_KICK: begin
        det_key = 1'b0;
        nxt     = ST_FEED;
      end
      ST_FEED: begin
        busy        = 1'b1;
        fft_s_valid = adc_valid;
        fft_s_last  = adc_valid && (beat_cnt == LAST_IDX);
        if (adc_valid && fft_s_ready && (beat_cnt == LAST_IDX)) nxt = ST_WAIT_MAG;
      end
      ST_WAIT_MAG: begin
        busy    = 1'b1;
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        ram_we  = mag_valid && bin_wr_ok_c;
        if (mag_valid && (ram_waddr == LAST_IDX)) begin
          nxt     = ST_DETECT;
          tmr_clr = 1'b1;
        end else if (tmr_exp) begin
          nxt    = ST_ERR;
          ram_we = 1'b0;
        end
      end
      ST_DETECT: begin
        busy    = 1'b1;
        det_en  = 1'b1;
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        if (det_valid)    nxt = ST_DONE;
        else if (tmr_exp) nxt = ST_ERR;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start_c || auto_run) nxt = ST_KICK;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start_c) nxt = ST_KICK;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Key resynchroniser; idle-high so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_d  <= 1'b1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  // Beat and bin counters wrap naturally at FFT_N (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      ram_waddr <= '0;
    end else if (state == ST_KICK) begin
      beat_cnt  <= '0;
      ram_waddr <= '0;
    end else begin
      if (state == ST_FEED && adc_valid && fft_s_ready) beat_cnt <= beat_cnt + ADDR_W'(1);
      if (state == ST_WAIT_MAG && mag_valid) ram_waddr <= ram_waddr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_type <= MODE_NONE;
    end else if (state == ST_DETECT && det_valid) begin
      mode_type <= det_mode;
    end else if (nxt == ST_ERR && state != ST_ERR) begin
      mode_type <= MODE_NONE;
    end
  end

endmodule

// File: tb/tb_spectrum_ctrl.sv
// Directed bench for spectrum_ctrl with FFT_N=16, TIMEOUT_CYC=64; honours SPECTRUM_CTRL_HALF_EN.
module tb_spectrum_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst_n, key, auto_run, adc_valid, fft_s_ready, mag_valid, det_valid;
  logic [2:0] det_mode;
  logic fft_s_valid, fft_s_last, ram_we, det_en, det_key, busy, done, err;
  logic [AW-1:0] ram_waddr;
  logic [2:0] mode_type;

  int checks = 0;
  int errors = 0;

  spectrum_ctrl #(.FFT_N(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .auto_run(auto_run),
    .adc_valid(adc_valid), .fft_s_valid(fft_s_valid), .fft_s_last(fft_s_last),
    .fft_s_ready(fft_s_ready), .mag_valid(mag_valid), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .det_en(det_en), .det_key(det_key),
    .det_valid(det_valid), .det_mode(det_mode), .mode_type(mode_type),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rst_vec_t;

  typedef struct packed {
    logic adc;
    logic rdy;
    logic exp_valid;
  } feed_vec_t;

  rst_vec_t  rv[10];
  feed_vec_t fv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rst_act(input int i);
    case (i)
      0: return 32'(fft_s_valid);
      1: return 32'(fft_s_last);
      2: return 32'(ram_we);
      3: return 32'(ram_waddr);
      4: return 32'(det_en);
      5: return 32'(det_key);
      6: return 32'(mode_type);
      7: return 32'(busy);
      8: return 32'(done);
      default: return 32'(err);
    endcase
  endfunction

  function automatic logic we_exp(input int bin);
`ifdef SPECTRUM_CTRL_HALF_EN
    return bin < int'(N / 2);
`else
    return (bin >= 0);
`endif
  endfunction

  task automatic check_reset(input string tag);
    for (int i = 0; i < 10; i++) chk({tag, "_", rv[i].name}, rst_act(i), rv[i].exp);
  endtask

  task automatic press_key(input string tag);
    bit got = 0;
    key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (det_key === 1'b0) begin got = 1; break; end
      chk({tag, "_busy_before_kick"}, 32'(busy), 32'd0);
    end
    chk({tag, "_kick_seen"}, 32'(got), 32'd1);
    key = 1'b1;
  endtask

  task automatic feed(input bit toggle, input string tag);
    int acc = 0;
    int lasts = 0;
    logic a, r;
    for (int c = 0; c < 200 && acc < int'(N); c++) begin
      @(negedge clk);
      a = toggle ? fv[c % 8].adc : 1'b1;
      r = toggle ? fv[c % 8].rdy : 1'b1;
      adc_valid = a; fft_s_ready = r;
      #1;
      if (c == 0) chk({tag, "_det_key_one_cycle"}, 32'(det_key), 32'd1);
      chk({tag, "_valid"}, 32'(fft_s_valid), toggle ? 32'(fv[c % 8].exp_valid) : 32'd1);
      chk({tag, "_last"}, 32'(fft_s_last), 32'(a && acc == int'(N) - 1));
      if (fft_s_last && r) lasts++;
      if (a && r) acc++;
    end
    chk({tag, "_accepted"}, 32'(acc), 32'(N));
    chk({tag, "_last_count"}, 32'(lasts), 32'd1);
  endtask

  task automatic mag(input int nbins, input string tag);
    for (int i = 0; i < nbins; i++) begin
      @(negedge clk);
      mag_valid = 1'b1;
      #1;
      if (i == 0) chk({tag, "_feed_closed"}, 32'(fft_s_valid), 32'd0);
      chk({tag, "_we"}, 32'(ram_we), 32'(we_exp(i)));
      chk({tag, "_waddr"}, 32'(ram_waddr), 32'(i));
      chk({tag, "_det_en_low"}, 32'(det_en), 32'd0);
    end
  endtask

  task automatic enter_detect(input string tag);
    @(negedge clk);
    mag_valid = 1'b0; adc_valid = 1'b0;
    #1;
    chk({tag, "_det_en_rise"}, 32'(det_en), 32'd1);
    chk({tag, "_we_off"}, 32'(ram_we), 32'd0);
  endtask

  task automatic detect_finish(input logic [2:0] mode, input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk({tag, "_det_en_hold"}, 32'(det_en), 32'd1);
    end
    @(negedge clk);
    det_valid = 1'b1; det_mode = mode;
    #1;
    @(negedge clk);
    det_valid = 1'b0; det_mode = 3'b000;
    #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_mode"}, 32'(mode_type), 32'(mode));
    chk({tag, "_det_en_off"}, 32'(det_en), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  task automatic full_pass(input logic [2:0] mode, input string tag);
    press_key(tag);
    feed(1'b0, tag);
    mag(int'(N), tag);
    enter_detect(tag);
    detect_finish(mode, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t;
    rv[0] = '{"fft_s_valid", 32'd0}; rv[1] = '{"fft_s_last", 32'd0};
    rv[2] = '{"ram_we", 32'd0};      rv[3] = '{"ram_waddr", 32'd0};
    rv[4] = '{"det_en", 32'd0};      rv[5] = '{"det_key", 32'd1};
    rv[6] = '{"mode_type", 32'd0};   rv[7] = '{"busy", 32'd0};
    rv[8] = '{"done", 32'd0};        rv[9] = '{"err", 32'd0};
    fv[0] = '{1'b1, 1'b1, 1'b1}; fv[1] = '{1'b1, 1'b0, 1'b1};
    fv[2] = '{1'b1, 1'b1, 1'b1}; fv[3] = '{1'b1, 1'b0, 1'b1};
    fv[4] = '{1'b0, 1'b1, 1'b0}; fv[5] = '{1'b1, 1'b0, 1'b1};
    fv[6] = '{1'b1, 1'b1, 1'b1}; fv[7] = '{1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; key = 1'b1; auto_run = 1'b0; adc_valid = 1'b0; fft_s_ready = 1'b0;
    mag_valid = 1'b0; det_valid = 1'b0; det_mode = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    full_pass(3'b010, "pass1");

    press_key("tog");
    feed(1'b1, "tog");
    mag(int'(N), "tog");
    enter_detect("tog");
    detect_finish(3'b001, "tog");

    // Magnitudes stall after 10 bins: timeout counted from WAIT_MAG entry.
    press_key("tmag");
    feed(1'b0, "tmag");
    mag(10, "tmag");
    t = 10;
    for (; t < 200; t++) begin
      @(negedge clk);
      mag_valid = 1'b0;
      #1;
      chk("tmag_det_en_never", 32'(det_en), 32'd0);
      if (err === 1'b1) break;
    end
    chk("tmag_cycles", 32'(t), 32'(TO));
    chk("tmag_mode_cleared", 32'(mode_type), 32'd0);
    chk("tmag_we_off", 32'(ram_we), 32'd0);
    chk("tmag_busy_off", 32'(busy), 32'd0);
    full_pass(3'b100, "after_err");

    // det_valid never comes: timeout counted from DETECT entry.
    press_key("tdet");
    feed(1'b0, "tdet");
    mag(int'(N), "tdet");
    enter_detect("tdet");
    t = 1;
    for (; t < 200; t++) begin
      @(negedge clk); #1;
      if (err === 1'b1) break;
      chk("tdet_det_en_hold", 32'(det_en), 32'd1);
    end
    chk("tdet_cycles", 32'(t), 32'(TO));
    chk("tdet_det_en_off", 32'(det_en), 32'd0);
    chk("tdet_mode_cleared", 32'(mode_type), 32'd0);

    // Auto-run: DONE followed directly by KICK, second result replaces the first.
    auto_run = 1'b1;
    press_key("auto1");
    feed(1'b0, "auto1");
    mag(int'(N), "auto1");
    enter_detect("auto1");
    detect_finish(3'b001, "auto1");
    @(negedge clk); #1;
    chk("auto_kick_det_key", 32'(det_key), 32'd0);
    chk("auto_kick_done_low", 32'(done), 32'd0);
    auto_run = 1'b0;
    feed(1'b0, "auto2");
    mag(int'(N), "auto2");
    enter_detect("auto2");
    detect_finish(3'b100, "auto2");
    repeat (2) @(negedge clk);
    #1;
    chk("auto_off_stays_done", 32'(done), 32'd1);

    // Reset while writing bin 7.
    press_key("mrst");
    feed(1'b0, "mrst");
    mag(7, "mrst");
    @(negedge clk);
    mag_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    mag_valid = 1'b0;
    rst_n = 1'b1;
    full_pass(3'b010, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
